core_mem_arbiter: RTL and testbench
===================================

# core_mem_arbiter

Single-port memory arbiter that shares one unified memory between the core's instruction-fetch port and its data port. It sits between `core` and the memory model: both core ports see a request/valid handshake, and the arbiter serialises their accesses onto one chip-selected memory port. The memory may insert wait states, and a timeout counter guards against a memory that never answers.

## Interface
- `DATA_WIDTH`, 32, width of addresses and data words
- `TIMEOUT`, 16, max BUSY cycles waiting for `mem_ready` before aborting; range 1..255
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `inst_req`  in  1  fetch request; held with `inst_address` stable until `inst_valid`
- `inst_address`  in  DATA_WIDTH  fetch address
- `inst`  out  DATA_WIDTH  fetched word, registered, holds until next fetch completes
- `inst_valid`  out  1  one-cycle pulse, fetch complete
- `data_req`  in  1  data request; held with address/we/w_data stable until `data_valid`
- `data_we`  in  1  1 = write, 0 = read
- `data_address`  in  DATA_WIDTH  load/store address
- `w_data`  in  DATA_WIDTH  store data
- `r_data`  out  DATA_WIDTH  load data, registered, updated only by completed reads
- `data_valid`  out  1  one-cycle pulse, data access complete
- `acc_err`  out  1  one-cycle pulse coincident with the valid pulse of a timed-out access
- `mem_csn`  out  1  memory chip select, active-low
- `mem_we`  out  1  memory write enable, meaningful only while `mem_csn`=0
- `mem_address`  out  DATA_WIDTH  memory address
- `mem_wdata`  out  DATA_WIDTH  memory write data
- `mem_rdata`  in  DATA_WIDTH  memory read data, valid when `mem_ready`=1
- `mem_ready`  in  1  memory completes the access in this cycle

## Operation
- FSM: IDLE, BUSY, DONE. Reset state IDLE.
- IDLE: if neither req, stay. Otherwise select winner (see Configuration), latch winner id, address, we, wdata into output registers, drive `mem_csn`=0 -> BUSY. Timeout counter cleared.
- BUSY: `mem_csn`=0 and all mem outputs held constant. `mem_ready`=1 -> capture `mem_rdata` into `inst` (inst winner) or `r_data` (data read winner; writes leave `r_data` unchanged), `mem_csn`=1 -> DONE. Counter reaching `TIMEOUT` without `mem_ready` -> capture zero instead of `mem_rdata`, set err flag, `mem_csn`=1 -> DONE.
- DONE: winner's valid = 1 for exactly this cycle; `acc_err`=1 if flagged; -> IDLE. Loser's request stays pending and is not dropped.
- Requests deasserted while not granted are ignored; a requester must not drop req between grant and valid (undefined otherwise, not checked).
- `inst_valid` and `data_valid` are never high in the same cycle.
- Reset, including mid-BUSY: FSM IDLE, `mem_csn`=1, `mem_we`=0, `mem_address`/`mem_wdata`/`inst`/`r_data`=0, valids and `acc_err`=0, counter 0, last-grant = data. Aborted access produces no valid pulse.

## Timing
- All outputs registered; no combinational path from inputs to outputs.
- req sampled high in IDLE at edge N -> `mem_csn`=0 from N+1.
- `mem_ready` sampled high at edge M (first possible M = N+1) -> valid high cycle after M, IDLE one cycle later.
- Zero-wait memory: 3 cycles per access, back-to-back throughput one access per 3 cycles.
- Timeout: valid + `acc_err` exactly `TIMEOUT`+1 cycles after entering BUSY.
- `mem_ready` outside BUSY is ignored.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined: on simultaneous requests in IDLE, grant the port not granted last; last-grant register updates on every grant, resets to data (first tie goes to fetch).
- Undefined: fixed priority, data always wins ties; last-grant register not built. Single requests are granted identically in both builds.

## Test plan
- Fetch only, zero-wait memory, `inst_address`=0x100, `mem_rdata`=0x00500093 -> `mem_csn` low 1 cycle, `inst`=0x00500093 and `inst_valid` 2 cycles after req.
- Store `data_address`=0x40, `w_data`=0xDEADBEEF, 3 wait states -> `mem_we`=1, `mem_wdata`=0xDEADBEEF held 4 cycles, `data_valid` pulse, `r_data` unchanged.
- Both req held continuously -> round-robin build: grants fetch, data, fetch, data; fixed build: data every grant, `inst_valid` never.
- `mem_ready` tied 0, `TIMEOUT`=16, load -> `data_valid` and `acc_err` 17 cycles after BUSY entry, `r_data`=0, FSM back to IDLE.
- `rst` low mid-BUSY -> immediately `mem_csn`=1, no valid pulse; after release pending req re-granted from IDLE.

Source files
------------

// File: rtl/core_mem_arbiter.sv
// Single-port memory arbiter serialising instruction fetches and data accesses onto one memory port.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise data wins every tie.
module core_mem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  inst_req_i,
    input  logic [DATA_WIDTH-1:0] inst_address_i,
    output logic [DATA_WIDTH-1:0] inst_o,
    output logic                  inst_valid_o,
    input  logic                  data_req_i,
    input  logic                  data_we_i,
    input  logic [DATA_WIDTH-1:0] data_address_i,
    input  logic [DATA_WIDTH-1:0] w_data_i,
    output logic [DATA_WIDTH-1:0] r_data_o,
    output logic                  data_valid_o,
    output logic                  acc_err_o,
    output logic                  mem_csn_o,
    output logic                  mem_we_o,
    output logic [DATA_WIDTH-1:0] mem_address_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    input  logic                  mem_ready_i
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_e                  state_q, state_d;
    logic                    winner_data_q, winner_data_d;
    logic [7:0]              cnt_q, cnt_d;
    logic                    mem_csn_q, mem_csn_d;
    logic                    mem_we_q, mem_we_d;
    logic [DATA_WIDTH-1:0]   mem_address_q, mem_address_d;
    logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_WIDTH-1:0]   inst_q, inst_d;
    logic [DATA_WIDTH-1:0]   r_data_q, r_data_d;
    logic                    inst_valid_q, inst_valid_d;
    logic                    data_valid_q, data_valid_d;
    logic                    acc_err_q, acc_err_d;
    logic                    grant_data;
    logic                    any_req;

    assign any_req = inst_req_i | data_req_i;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_grant_data_q, last_grant_data_d;

    // On a tie the port that did not win last time is served.
    assign grant_data = data_req_i & (~inst_req_i | ~last_grant_data_q);

    always_comb begin
        last_grant_data_d = last_grant_data_q;
        if (state_q == IDLE && any_req) begin
            last_grant_data_d = grant_data;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_grant_data_q <= 1'b1;
        end else begin
            last_grant_data_q <= last_grant_data_d;
        end
    end
`else
    assign grant_data = data_req_i;
`endif

    always_comb begin
        state_d       = state_q;
        winner_data_d = winner_data_q;
        cnt_d         = cnt_q;
        mem_csn_d     = mem_csn_q;
        mem_we_d      = mem_we_q;
        mem_address_d = mem_address_q;
        mem_wdata_d   = mem_wdata_q;
        inst_d        = inst_q;
        r_data_d      = r_data_q;
        inst_valid_d  = 1'b0;
        data_valid_d  = 1'b0;
        acc_err_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    winner_data_d = grant_data;
                    mem_csn_d     = 1'b0;
                    mem_we_d      = grant_data & data_we_i;
                    mem_address_d = grant_data ? data_address_i : inst_address_i;
                    mem_wdata_d   = grant_data ? w_data_i : '0;
                    cnt_d         = 8'd0;
                    state_d       = BUSY;
                end
            end
            BUSY: begin
                // A late ready on the abort cycle still completes the access normally.
                if (mem_ready_i || cnt_q == TIMEOUT_CNT) begin
                    if (!winner_data_q) begin
                        inst_d = mem_ready_i ? mem_rdata_i : '0;
                    end else if (!mem_we_q) begin
                        r_data_d = mem_ready_i ? mem_rdata_i : '0;
                    end
                    acc_err_d    = ~mem_ready_i;
                    inst_valid_d = ~winner_data_q;
                    data_valid_d = winner_data_q;
                    mem_csn_d    = 1'b1;
                    state_d      = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            winner_data_q <= 1'b0;
            cnt_q         <= 8'd0;
            mem_csn_q     <= 1'b1;
            mem_we_q      <= 1'b0;
            mem_address_q <= '0;
            mem_wdata_q   <= '0;
            inst_q        <= '0;
            r_data_q      <= '0;
            inst_valid_q  <= 1'b0;
            data_valid_q  <= 1'b0;
            acc_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            winner_data_q <= winner_data_d;
            cnt_q         <= cnt_d;
            mem_csn_q     <= mem_csn_d;
            mem_we_q      <= mem_we_d;
            mem_address_q <= mem_address_d;
            mem_wdata_q   <= mem_wdata_d;
            inst_q        <= inst_d;
            r_data_q      <= r_data_d;
            inst_valid_q  <= inst_valid_d;
            data_valid_q  <= data_valid_d;
            acc_err_q     <= acc_err_d;
        end
    end

    assign inst_o        = inst_q;
    assign inst_valid_o  = inst_valid_q;
    assign r_data_o      = r_data_q;
    assign data_valid_o  = data_valid_q;
    assign acc_err_o     = acc_err_q;
    assign mem_csn_o     = mem_csn_q;
    assign mem_we_o      = mem_we_q;
    assign mem_address_o = mem_address_q;
    assign mem_wdata_o   = mem_wdata_q;

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Scoreboard bench for core_mem_arbiter: a wait-state memory model answers the DUT,
// expected completions are queued when requests are driven and popped on each valid pulse.
module tb_core_mem_arbiter;

    localparam int DW = 32;
    localparam int TO = 16;

    typedef struct {
        logic        isData;
        logic [31:0] value;
        logic        err;
    } exp_t;

    typedef struct {
        logic        got;
        logic        isData;
        logic [31:0] value;
        logic        err;
        int          cycles;
        int          lowCnt;
        logic        holdOk;
        logic        bothHigh;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
    } obs_t;

    logic          clk;
    logic          rstN;
    logic          instReq;
    logic [DW-1:0] instAddress;
    logic [DW-1:0] inst;
    logic          instValid;
    logic          dataReq;
    logic          dataWe;
    logic [DW-1:0] dataAddress;
    logic [DW-1:0] wData;
    logic [DW-1:0] rData;
    logic          dataValid;
    logic          accErr;
    logic          memCsn;
    logic          memWe;
    logic [DW-1:0] memAddress;
    logic [DW-1:0] memWdata;
    logic [DW-1:0] memRdata;
    logic          memReady;

    int            testsRun;
    int            testsFailed;
    exp_t          expQ[$];
    logic [31:0]   memArr [logic [31:0]];
    int            waitStates;
    logic          memDead;
    logic          lastGrantData;
    logic [31:0]   lastRData;

    core_mem_arbiter #(
        .DATA_WIDTH(DW),
        .TIMEOUT   (TO)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rstN),
        .inst_req_i    (instReq),
        .inst_address_i(instAddress),
        .inst_o        (inst),
        .inst_valid_o  (instValid),
        .data_req_i    (dataReq),
        .data_we_i     (dataWe),
        .data_address_i(dataAddress),
        .w_data_i      (wData),
        .r_data_o      (rData),
        .data_valid_o  (dataValid),
        .acc_err_o     (accErr),
        .mem_csn_o     (memCsn),
        .mem_we_o      (memWe),
        .mem_address_o (memAddress),
        .mem_wdata_o   (memWdata),
        .mem_rdata_i   (memRdata),
        .mem_ready_i   (memReady)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: answers after waitStates low-chip-select cycles, never when memDead is set.
    initial begin
        int waitCnt;
        waitCnt  = 0;
        memReady = 1'b0;
        memRdata = 32'h5A5A5A5A;
        forever begin
            @(negedge clk);
            if (memCsn === 1'b0 && !memDead) begin
                if (waitCnt >= waitStates) begin
                    memReady = 1'b1;
                    memRdata = memArr.exists(memAddress) ? memArr[memAddress] : 32'h0;
                    if (memWe === 1'b1) memArr[memAddress] = memWdata;
                end else begin
                    memReady = 1'b0;
                end
                waitCnt++;
            end else begin
                memReady = 1'b0;
                memRdata = 32'h5A5A5A5A;
                if (memCsn !== 1'b0) waitCnt = 0;
            end
        end
    end

    task automatic waitValid(input int budget, output obs_t o);
        logic first;
        first      = 1'b1;
        o.got      = 1'b0;
        o.isData   = 1'b0;
        o.value    = '0;
        o.err      = 1'b0;
        o.cycles   = 0;
        o.lowCnt   = 0;
        o.holdOk   = 1'b1;
        o.bothHigh = 1'b0;
        o.addr     = '0;
        o.wdata    = '0;
        o.we       = 1'b0;
        while (!o.got && o.cycles < budget) begin
            @(negedge clk);
            o.cycles++;
            if (memCsn === 1'b0) begin
                o.lowCnt++;
                if (first) begin
                    o.addr  = memAddress;
                    o.wdata = memWdata;
                    o.we    = memWe;
                    first   = 1'b0;
                end else if (memAddress !== o.addr || memWdata !== o.wdata || memWe !== o.we) begin
                    o.holdOk = 1'b0;
                end
            end
            if (instValid === 1'b1 || dataValid === 1'b1) begin
                o.got      = 1'b1;
                o.bothHigh = instValid & dataValid;
                o.isData   = dataValid;
                o.value    = (dataValid === 1'b1) ? rData : inst;
                o.err      = accErr;
            end
        end
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        repeat (2) @(negedge clk);
        testsRun++;
        if ({memCsn, memWe, instValid, dataValid, accErr} !== 5'b10000) begin
            testsFailed++;
            $display("[TB] FAIL reset_ctrl got csn/we/iv/dv/err=%b required 10000",
                     {memCsn, memWe, instValid, dataValid, accErr});
        end
        testsRun++;
        if (memAddress !== '0 || memWdata !== '0) begin
            testsFailed++;
            $display("[TB] FAIL reset_mem got addr=%h wdata=%h required 0", memAddress, memWdata);
        end
        testsRun++;
        if (inst !== '0 || rData !== '0) begin
            testsFailed++;
            $display("[TB] FAIL reset_data got inst=%h r_data=%h required 0", inst, rData);
        end
        rstN          = 1'b1;
        lastGrantData = 1'b1;
        lastRData     = '0;
        @(negedge clk);
    endtask

    task automatic test_fetch();
        obs_t o;
        exp_t e;
        memArr[32'h100] = 32'h00500093;
        waitStates      = 0;
        instAddress     = 32'h100;
        instReq         = 1'b1;
        expQ.push_back('{1'b0, 32'h00500093, 1'b0});
        lastGrantData = 1'b0;
        waitValid(10, o);
        instReq = 1'b0;
        e = expQ.pop_front();
        testsRun++;
        if (!o.got || o.isData !== e.isData || o.value !== e.value || o.err !== e.err) begin
            testsFailed++;
            $display("[TB] FAIL fetch_result got got=%b isData=%b value=%h err=%b required isData=%b value=%h err=%b",
                     o.got, o.isData, o.value, o.err, e.isData, e.value, e.err);
        end
        testsRun++;
        if (o.cycles !== 2 || o.lowCnt !== 1) begin
            testsFailed++;
            $display("[TB] FAIL fetch_timing got cycles=%0d csnLow=%0d required 2 and 1", o.cycles, o.lowCnt);
        end
        testsRun++;
        if (o.addr !== 32'h100 || o.we !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL fetch_mem got addr=%h we=%b required 00000100 0", o.addr, o.we);
        end
        @(negedge clk);
        testsRun++;
        if (instValid !== 1'b0 || memCsn !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL fetch_pulse got inst_valid=%b csn=%b required 0 1", instValid, memCsn);
        end
    endtask

    task automatic test_load();
        obs_t o;
        exp_t e;
        memArr[32'h80] = 32'h12345678;
        waitStates     = 1;
        dataAddress    = 32'h80;
        dataWe         = 1'b0;
        dataReq        = 1'b1;
        expQ.push_back('{1'b1, 32'h12345678, 1'b0});
        lastGrantData = 1'b1;
        lastRData     = 32'h12345678;
        waitValid(10, o);
        dataReq = 1'b0;
        e = expQ.pop_front();
        testsRun++;
        if (!o.got || o.isData !== e.isData || o.value !== e.value || o.err !== e.err || o.cycles !== 3) begin
            testsFailed++;
            $display("[TB] FAIL load_result got got=%b isData=%b value=%h err=%b cycles=%0d required isData=%b value=%h err=%b cycles=3",
                     o.got, o.isData, o.value, o.err, o.cycles, e.isData, e.value, e.err);
        end
        @(negedge clk);
    endtask

    task automatic test_store();
        obs_t o;
        exp_t e;
        waitStates  = 3;
        dataAddress = 32'h40;
        wData       = 32'hDEADBEEF;
        dataWe      = 1'b1;
        dataReq     = 1'b1;
        expQ.push_back('{1'b1, lastRData, 1'b0});
        lastGrantData = 1'b1;
        waitValid(20, o);
        dataReq = 1'b0;
        dataWe  = 1'b0;
        e = expQ.pop_front();
        testsRun++;
        if (!o.got || o.isData !== e.isData || o.value !== e.value || o.err !== e.err) begin
            testsFailed++;
            $display("[TB] FAIL store_result got got=%b isData=%b r_data=%h err=%b required isData=%b r_data=%h err=%b",
                     o.got, o.isData, o.value, o.err, e.isData, e.value, e.err);
        end
        testsRun++;
        if (o.we !== 1'b1 || o.wdata !== 32'hDEADBEEF || o.addr !== 32'h40 || !o.holdOk || o.lowCnt !== 4) begin
            testsFailed++;
            $display("[TB] FAIL store_mem got we=%b wdata=%h addr=%h held=%b csnLow=%0d required 1 deadbeef 00000040 1 4",
                     o.we, o.wdata, o.addr, o.holdOk, o.lowCnt);
        end
        testsRun++;
        if (memArr[32'h40] !== 32'hDEADBEEF) begin
            testsFailed++;
            $display("[TB] FAIL store_written got %h required deadbeef", memArr[32'h40]);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        obs_t o;
        exp_t e;
        logic g;
        memArr[32'h200] = 32'hAAAA0001;
        memArr[32'h300] = 32'hBBBB0002;
        waitStates      = 0;
        instAddress     = 32'h200;
        dataAddress     = 32'h300;
        dataWe          = 1'b0;
        for (int i = 0; i < 4; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
            g = ~lastGrantData;
`else
            g = 1'b1;
`endif
            expQ.push_back('{g, g ? 32'hBBBB0002 : 32'hAAAA0001, 1'b0});
            lastGrantData = g;
            if (g) lastRData = 32'hBBBB0002;
        end
        instReq = 1'b1;
        dataReq = 1'b1;
        for (int i = 0; i < 4; i++) begin
            waitValid(10, o);
            e = expQ.pop_front();
            testsRun++;
            if (!o.got || o.bothHigh || o.isData !== e.isData || o.value !== e.value || o.err !== e.err) begin
                testsFailed++;
                $display("[TB] FAIL b2b_grant%0d got got=%b both=%b isData=%b value=%h err=%b required isData=%b value=%h err=%b",
                         i, o.got, o.bothHigh, o.isData, o.value, o.err, e.isData, e.value, e.err);
            end
            testsRun++;
            if (o.cycles !== ((i == 0) ? 2 : 3)) begin
                testsFailed++;
                $display("[TB] FAIL b2b_spacing%0d got %0d cycles required %0d", i, o.cycles, (i == 0) ? 2 : 3);
            end
        end
        instReq = 1'b0;
        dataReq = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        obs_t o;
        exp_t e;
        memDead     = 1'b1;
        dataAddress = 32'h80;
        dataWe      = 1'b0;
        dataReq     = 1'b1;
        expQ.push_back('{1'b1, 32'h0, 1'b1});
        lastGrantData = 1'b1;
        lastRData     = '0;
        waitValid(TO + 20, o);
        dataReq = 1'b0;
        e = expQ.pop_front();
        testsRun++;
        if (!o.got || o.isData !== e.isData || o.value !== e.value || o.err !== e.err) begin
            testsFailed++;
            $display("[TB] FAIL timeout_result got got=%b isData=%b r_data=%h err=%b required isData=%b r_data=%h err=%b",
                     o.got, o.isData, o.value, o.err, e.isData, e.value, e.err);
        end
        testsRun++;
        if (o.cycles !== TO + 2 || o.lowCnt !== TO + 1) begin
            testsFailed++;
            $display("[TB] FAIL timeout_timing got cycles=%0d csnLow=%0d required %0d and %0d",
                     o.cycles, o.lowCnt, TO + 2, TO + 1);
        end
        @(negedge clk);
        testsRun++;
        if (memCsn !== 1'b1 || dataValid !== 1'b0 || accErr !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL timeout_after got csn=%b dv=%b err=%b required 1 0 0", memCsn, dataValid, accErr);
        end
        memDead = 1'b0;
    endtask

    task automatic test_reset_mid_busy();
        obs_t o;
        exp_t e;
        logic sawValid;
        waitStates  = 5;
        instAddress = 32'h200;
        instReq     = 1'b1;
        repeat (2) @(negedge clk);
        testsRun++;
        if (memCsn !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL midrst_busy got csn=%b required 0", memCsn);
        end
        rstN = 1'b0;
        #1;
        testsRun++;
        if (memCsn !== 1'b1 || memWe !== 1'b0 || inst !== '0 || rData !== '0 || memAddress !== '0) begin
            testsFailed++;
            $display("[TB] FAIL midrst_async got csn=%b we=%b inst=%h r_data=%h addr=%h required 1 0 0 0 0",
                     memCsn, memWe, inst, rData, memAddress);
        end
        sawValid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (instValid !== 1'b0 || dataValid !== 1'b0 || accErr !== 1'b0) sawValid = 1'b1;
        end
        rstN = 1'b1;
        testsRun++;
        if (sawValid) begin
            testsFailed++;
            $display("[TB] FAIL midrst_novalid got a valid/err pulse during reset required none");
        end
        lastGrantData = 1'b0;
        expQ.push_back('{1'b0, 32'hAAAA0001, 1'b0});
        waitValid(20, o);
        instReq = 1'b0;
        e = expQ.pop_front();
        testsRun++;
        if (!o.got || o.isData !== e.isData || o.value !== e.value || o.err !== e.err || o.cycles !== 7) begin
            testsFailed++;
            $display("[TB] FAIL midrst_regrant got got=%b isData=%b value=%h err=%b cycles=%0d required isData=%b value=%h err=%b cycles=7",
                     o.got, o.isData, o.value, o.err, o.cycles, e.isData, e.value, e.err);
        end
        @(negedge clk);
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        rstN        = 1'b0;
        instReq     = 1'b0;
        instAddress = '0;
        dataReq     = 1'b0;
        dataWe      = 1'b0;
        dataAddress = '0;
        wData       = '0;
        waitStates  = 0;
        memDead     = 1'b0;
        test_reset();
        test_fetch();
        test_load();
        test_store();
        test_back_to_back();
        test_timeout();
        test_reset_mid_busy();
        testsRun++;
        if (expQ.size() != 0) begin
            testsFailed++;
            $display("[TB] FAIL scoreboard_drain got %0d pending required 0", expQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation did not complete within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
